// File: rtl/pipeline_drain_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_drain_if
//  Description : Beat stream bundle for pipeline_drain. Carries the
//                no-backpressure input beat (data_in/valid_in) and the
//                re-issued valid/ready output stream (m_data/m_valid/m_ready).
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_drain_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  valid_in;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    // Producer of input beats and consumer of the drained stream
    modport master (
        output data_in,
        output valid_in,
        output m_ready,
        input  m_data,
        input  m_valid
    );

    // The drain block itself
    modport slave (
        input  data_in,
        input  valid_in,
        input  m_ready,
        output m_data,
        output m_valid
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_drain.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_drain
//  Description : Captures the pipeline output beat stream into a FIFO,
//                re-issues it on a valid/ready handshake and flags completion
//                once a programmed number of beats has been received and
//                drained. Optional checksum port enabled by defining
//                PIPELINE_DRAIN_CHECKSUM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_drain #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  wire                         clk,
    input  wire                         reset,
    input  wire                         enable,
    input  wire                         start,
    input  wire  [CNT_WIDTH-1:0]        expect_count,
    pipeline_drain_if.slave             bus,
    output logic [$clog2(DEPTH+1)-1:0]  level,
    output logic                        busy,
    output logic                        done,
    output logic                        overflow,
    output logic [CNT_WIDTH-1:0]        rx_count
`ifdef PIPELINE_DRAIN_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0]       checksum
`endif
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_lw = $clog2(DEPTH + 1);

    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_collect = 2'd1;
    localparam logic [1:0] c_drain   = 2'd2;
    localparam logic [1:0] c_done    = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]       r_wr_ptr;
    logic [c_aw-1:0]       r_rd_ptr;
    logic [c_lw-1:0]       r_level;
    logic [c_lw-1:0]       w_level_nxt;
    logic                  r_m_valid;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_overflow;
    logic [CNT_WIDTH-1:0]  r_rx_count;
    logic [CNT_WIDTH-1:0]  r_target;

    logic w_recv;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_start_ok;
    logic w_last;

    // A beat only counts while collecting; a full FIFO still takes it if a pop frees a slot
    assign w_recv     = (r_state == c_collect) && bus.valid_in && enable;
    assign w_full     = (r_level == c_lw'(DEPTH));
    assign w_pop      = r_m_valid && bus.m_ready;
    assign w_push     = w_recv && (!w_full || w_pop);
    assign w_drop     = w_recv && !w_push;
    assign w_start_ok = start && ((r_state == c_idle) || (r_state == c_done));
    assign w_last     = w_recv && ((r_rx_count + CNT_WIDTH'(1)) == r_target);

    // Next state: start is only honoured from IDLE/DONE; DRAIN ends when the FIFO empties
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle, c_done: begin
                if (start) begin
                    w_state_nxt = (expect_count != '0) ? c_collect : c_done;
                end
            end
            c_collect: begin
                if (w_last) begin
                    w_state_nxt = c_drain;
                end
            end
            c_drain: begin
                if ((r_level == '0) || (w_pop && (r_level == c_lw'(1)))) begin
                    w_state_nxt = c_done;
                end
            end
            default: w_state_nxt = c_idle;
        endcase
    end

    // State register with busy/done registered alongside so they change on the same edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_idle;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == c_collect) || (w_state_nxt == c_drain);
            r_done  <= (w_state_nxt == c_done);
        end
    end

    // Transaction bookkeeping: target, received-beat count and sticky drop flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_target   <= '0;
            r_rx_count <= '0;
            r_overflow <= 1'b0;
        end else if (w_start_ok) begin
            r_target   <= expect_count;
            r_rx_count <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_recv && (r_rx_count != r_target)) begin
                r_rx_count <= r_rx_count + CNT_WIDTH'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Occupancy after this cycle's push/pop; a simultaneous push and pop leaves it unchanged
    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + c_lw'(1);
            2'b01:   w_level_nxt = r_level - c_lw'(1);
            default: w_level_nxt = r_level;
        endcase
    end

    // FIFO pointers, occupancy and registered non-empty flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_m_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            r_level   <= w_level_nxt;
            r_m_valid <= (w_level_nxt != '0);
        end
    end

    // Storage array; not reset because the head is masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.data_in;
        end
    end

`ifdef PIPELINE_DRAIN_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_checksum;

    // Running sum of beats actually written into the FIFO this transaction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_checksum <= '0;
        end else if (w_start_ok) begin
            r_checksum <= '0;
        end else if (w_push) begin
            r_checksum <= r_checksum + bus.data_in;
        end
    end

    assign checksum = r_checksum;
`endif

    assign bus.m_data  = r_m_valid ? r_mem[r_rd_ptr] : '0;
    assign bus.m_valid = r_m_valid;
    assign level       = r_level;
    assign busy        = r_busy;
    assign done        = r_done;
    assign overflow    = r_overflow;
    assign rx_count    = r_rx_count;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_drain
//  Description : Directed self-checking bench for pipeline_drain with a
//                scoreboard queue of expected drained beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_drain;

    localparam int DW = 32;
    localparam int DEPTH = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] expect_count = '0;
    logic [3:0]    level;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [CW-1:0] rx_count;
`ifdef PIPELINE_DRAIN_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    pipeline_drain_if #(.DATA_WIDTH(DW)) bus ();

    pipeline_drain #(
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .reset(rst),
        .enable(enable),
        .start(start),
        .expect_count(expect_count),
        .bus(bus),
        .level(level),
        .busy(busy),
        .done(done),
        .overflow(overflow),
        .rx_count(rx_count)
`ifdef PIPELINE_DRAIN_CHECKSUM_EN
        ,
        .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_pass = 0;
    int          n_pops = 0;
    logic [63:0] sb[$];
    logic [DW-1:0] model_sum = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_txn(input int n);
        start        = 1'b1;
        expect_count = CW'(n);
        model_sum    = '0;
        tick();
        start        = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input bit accepted);
        bus.valid_in = 1'b1;
        bus.data_in  = d;
        if (accepted) begin
            sb.push_back({32'h0, d});
            model_sum = model_sum + d;
        end
        tick();
        bus.valid_in = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!done && k < 100) begin
            tick();
            k++;
        end
        chk(tag, {63'h0, done}, 64'h1);
    endtask

    // Scoreboard: every handshake must deliver the oldest outstanding expected beat
    always @(negedge clk) begin
        if (!rst && bus.m_valid && bus.m_ready) begin
            logic [63:0] exp;
            exp = (sb.size() > 0) ? sb.pop_front() : 64'hDEAD_0000_0000_0000;
            n_pops++;
            chk("drain_data", {32'h0, bus.m_data}, exp);
        end
    end

    initial begin
        #200000;
        $error("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pops0;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        bus.m_ready  = 1'b0;

        // ---------------- reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_done", {63'h0, done}, 64'h0);
        chk("rst_mvalid", {63'h0, bus.m_valid}, 64'h0);
        chk("rst_level", {60'h0, level}, 64'h0);
        chk("rst_ovf", {63'h0, overflow}, 64'h0);
        chk("rst_rx", {48'h0, rx_count}, 64'h0);
        chk("rst_mdata", {32'h0, bus.m_data}, 64'h0);
        tick();

        // ---------------- basic single beat
        bus.m_ready = 1'b1;
        pops0 = n_pops;
        start_txn(1);
        chk("basic_busy", {63'h0, busy}, 64'h1);
        send_beat(32'hA5A5A5A5, 1'b1);
        chk("basic_mvalid", {63'h0, bus.m_valid}, 64'h1);
        wait_done("basic_done");
        chk("basic_rx", {48'h0, rx_count}, 64'd1);
        chk("basic_pops", 64'(n_pops - pops0), 64'd1);
        chk("basic_mvalid_off", {63'h0, bus.m_valid}, 64'h0);
`ifdef PIPELINE_DRAIN_CHECKSUM_EN
        chk("basic_csum", {32'h0, checksum}, {32'h0, model_sum});
`endif
        tick();
        tick();
        chk("done_sticky", {63'h0, done}, 64'h1);

        // ---------------- backpressure
        bus.m_ready = 1'b0;
        start_txn(3);
        chk("bp_done_clear", {63'h0, done}, 64'h0);
        send_beat(32'h12345678, 1'b1);
        send_beat(32'h87654321, 1'b1);
        send_beat(32'hDEADBEEF, 1'b1);
        tick();
        tick();
        chk("bp_level", {60'h0, level}, 64'd3);
        chk("bp_busy", {63'h0, busy}, 64'h1);
        chk("bp_done", {63'h0, done}, 64'h0);
        bus.m_ready = 1'b1;
        wait_done("bp_done_final");
        chk("bp_sb_empty", 64'(sb.size()), 64'd0);
`ifdef PIPELINE_DRAIN_CHECKSUM_EN
        chk("bp_csum", {32'h0, checksum}, {32'h0, model_sum});
`endif

        // ---------------- overflow
        bus.m_ready = 1'b0;
        pops0 = n_pops;
        start_txn(10);
        for (int i = 0; i < 10; i++) begin
            send_beat(32'hC000_0000 + 32'(i), (i < DEPTH));
        end
        chk("ovf_level", {60'h0, level}, 64'd8);
        chk("ovf_flag", {63'h0, overflow}, 64'h1);
        chk("ovf_rx", {48'h0, rx_count}, 64'd10);
        chk("ovf_busy_drain", {62'h0, busy, done}, 64'b10);
`ifdef PIPELINE_DRAIN_CHECKSUM_EN
        chk("ovf_csum", {32'h0, checksum}, {32'h0, model_sum});
`endif
        bus.m_ready = 1'b1;
        wait_done("ovf_done");
        chk("ovf_pops", 64'(n_pops - pops0), 64'd8);
        chk("ovf_sb_empty", 64'(sb.size()), 64'd0);

        // ---------------- full with simultaneous push and pop
        bus.m_ready = 1'b0;
        start_txn(10);
        chk("full_ovf_cleared", {63'h0, overflow}, 64'h0);
        for (int i = 0; i < DEPTH; i++) begin
            send_beat(32'h5000_0000 + 32'(i), 1'b1);
        end
        chk("full_level", {60'h0, level}, 64'd8);
        bus.m_ready = 1'b1;
        send_beat(32'h5000_0008, 1'b1);
        chk("full_pp_level", {60'h0, level}, 64'd8);
        chk("full_pp_ovf", {63'h0, overflow}, 64'h0);
        send_beat(32'h5000_0009, 1'b1);
        chk("full_pp_level2", {60'h0, level}, 64'd8);
        wait_done("full_done");
        chk("full_ovf_final", {63'h0, overflow}, 64'h0);
        chk("full_sb_empty", 64'(sb.size()), 64'd0);

        // ---------------- reset mid-operation
        bus.m_ready = 1'b0;
        start_txn(5);
        send_beat(32'h0000_0001, 1'b0);
        send_beat(32'h0000_0002, 1'b0);
        send_beat(32'h0000_0003, 1'b0);
        chk("mid_level", {60'h0, level}, 64'd3);
        rst = 1'b1;
        #1;
        chk("mid_async_level", {60'h0, level}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_busy", {63'h0, busy}, 64'h0);
        chk("mid_done", {63'h0, done}, 64'h0);
        chk("mid_mvalid", {63'h0, bus.m_valid}, 64'h0);
        chk("mid_ovf", {63'h0, overflow}, 64'h0);
        chk("mid_mdata", {32'h0, bus.m_data}, 64'h0);
        bus.m_ready = 1'b1;
        send_beat(32'h0BAD_0001, 1'b0);
        send_beat(32'h0BAD_0002, 1'b0);
        chk("mid_ignore_level", {60'h0, level}, 64'd0);
        chk("mid_ignore_rx", {48'h0, rx_count}, 64'd0);
        chk("mid_ignore_mvalid", {63'h0, bus.m_valid}, 64'h0);

        // ---------------- enable low
        bus.m_ready = 1'b0;
        start_txn(2);
        enable = 1'b0;
        send_beat(32'h22222222, 1'b0);
        send_beat(32'h22222222, 1'b0);
        chk("en_rx", {48'h0, rx_count}, 64'd0);
        chk("en_level", {60'h0, level}, 64'd0);
        enable = 1'b1;
        send_beat(32'h33333333, 1'b1);
        chk("en_rx_after", {48'h0, rx_count}, 64'd1);
        chk("en_level_after", {60'h0, level}, 64'd1);
        send_beat(32'h44444444, 1'b1);
        bus.m_ready = 1'b1;
        wait_done("en_done");
        chk("en_sb_empty", 64'(sb.size()), 64'd0);

        // ---------------- start ignored while collecting
        start_txn(2);
        send_beat(32'h55555555, 1'b1);
        start        = 1'b1;
        expect_count = 16'd7;
        tick();
        start        = 1'b0;
        chk("ign_rx", {48'h0, rx_count}, 64'd1);
        chk("ign_busy", {63'h0, busy}, 64'h1);
        send_beat(32'h66666666, 1'b1);
        wait_done("ign_done");
        chk("ign_rx_final", {48'h0, rx_count}, 64'd2);

        // ---------------- zero-length transaction
        start_txn(0);
        chk("zero_done", {63'h0, done}, 64'h1);
        chk("zero_busy", {63'h0, busy}, 64'h0);
        chk("zero_rx", {48'h0, rx_count}, 64'd0);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
